// File: rtl/ps2_key_ctl_if.sv
// Signal bundle between the PS/2 keyboard pins, the key-level consumers and
// the ps2_key_ctl block. The slave side is the controller itself.
interface ps2_key_ctl_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       left;
  logic       right;
  logic       fire;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_err;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output left,
    output right,
    output fire,
    output byte_out,
    output byte_valid,
    output frame_err
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    input  left,
    input  right,
    input  fire,
    input  byte_out,
    input  byte_valid,
    input  frame_err
  );
endinterface

// File: rtl/ps2_key_ctl.sv
// PS/2 keyboard receiver: synchronises the keyboard lines, deframes bytes with
// parity/stop/timeout checking and turns make/break codes into held-key levels.
module ps2_key_ctl #(
  parameter int unsigned TIMEOUT_CYCLES = 65000,
  parameter logic [7:0]  LEFT_CODE      = 8'h6B,
  parameter logic [7:0]  RIGHT_CODE     = 8'h74,
  parameter logic [7:0]  FIRE_CODE      = 8'h29
) (
  input logic          pclk,
  input logic          rst,
  ps2_key_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0]  BREAK_CODE  = 8'hF0;
  localparam logic [7:0]  EXT_CODE    = 8'hE0;
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

  // A frame is good when the data bits plus the parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

  logic        ps2_clk_meta_r;
  logic        ps2_clk_sync_r;
  logic        ps2_clk_prev_r;
  logic        ps2_data_meta_r;
  logic        ps2_data_sync_r;
  logic        fall_s;
  logic        data_s;

  rx_state_t   state_r;
  rx_state_t   state_s;
  logic [2:0]  bit_cnt_r;
  logic [2:0]  bit_cnt_s;
  logic [7:0]  shift_r;
  logic [7:0]  shift_s;
  logic        parity_r;
  logic        parity_s;
  logic [16:0] timer_r;
  logic [16:0] timer_s;
  logic [16:0] timer_inc_s;
  logic        timeout_s;

  logic [7:0]  byte_out_r;
  logic [7:0]  byte_out_s;
  logic        byte_valid_r;
  logic        byte_valid_s;
  logic        frame_err_r;
  logic        frame_err_s;

  logic        ext_r;
  logic        ext_s;
  logic        brk_r;
  logic        brk_s;
  logic        left_r;
  logic        left_s;
  logic        right_r;
  logic        right_s;
  logic        fire_r;
  logic        fire_s;

  // Two-flop synchronisers plus a history flop on the clock for edge detection.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      ps2_clk_meta_r  <= 1'b1;
      ps2_clk_sync_r  <= 1'b1;
      ps2_clk_prev_r  <= 1'b1;
      ps2_data_meta_r <= 1'b1;
      ps2_data_sync_r <= 1'b1;
    end else begin
      ps2_clk_meta_r  <= bus.ps2_clk;
      ps2_clk_sync_r  <= ps2_clk_meta_r;
      ps2_clk_prev_r  <= ps2_clk_sync_r;
      ps2_data_meta_r <= bus.ps2_data;
      ps2_data_sync_r <= ps2_data_meta_r;
    end
  end

  assign fall_s = ps2_clk_prev_r & ~ps2_clk_sync_r;
  assign data_s = ps2_data_sync_r;

  // Inactivity timer; a falling edge in the same cycle always wins over the abort.
  always_comb begin
    timer_inc_s = timer_r + 17'd1;
    timeout_s   = 1'b0;
    timer_s     = timer_inc_s;
    if ((state_r != ST_IDLE) && !fall_s && (timer_inc_s == TIMEOUT_LIM)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    if (fall_s || (state_r == ST_IDLE) || timeout_s) begin
      timer_s = 17'd0;
    end else begin
      timer_s = timer_inc_s;
    end
  end

  // Receiver next-state and frame result logic.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shift_s      = shift_r;
    parity_s     = parity_r;
    byte_out_s   = byte_out_r;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s && !data_s) begin
          state_s   = ST_DATA;
          bit_cnt_s = 3'd0;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_s = {data_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_s   = ST_PARITY;
            bit_cnt_s = 3'd0;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else if (timeout_s) begin
          state_s     = ST_IDLE;
          frame_err_s = 1'b1;
        end else begin
          state_s     = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          parity_s = data_s;
          state_s  = ST_STOP;
        end else if (timeout_s) begin
          state_s     = ST_IDLE;
          frame_err_s = 1'b1;
        end else begin
          state_s     = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_s = ST_IDLE;
          if (data_s && odd_parity_ok(shift_r, parity_r)) begin
            byte_out_s   = shift_r;
            byte_valid_s = 1'b1;
          end else begin
            frame_err_s  = 1'b1;
          end
        end else if (timeout_s) begin
          state_s     = ST_IDLE;
          frame_err_s = 1'b1;
        end else begin
          state_s     = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Receiver state and registered frame results.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      parity_r     <= 1'b0;
      timer_r      <= 17'd0;
      byte_out_r   <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      shift_r      <= shift_s;
      parity_r     <= parity_s;
      timer_r      <= timer_s;
      byte_out_r   <= byte_out_s;
      byte_valid_r <= byte_valid_s;
      frame_err_r  <= frame_err_s;
    end
  end

  // Scan-code decoder: prefixes arm flags, the next plain code consumes them.
  always_comb begin
    ext_s   = ext_r;
    brk_s   = brk_r;
    left_s  = left_r;
    right_s = right_r;
    fire_s  = fire_r;
    if (byte_valid_r) begin
      case (byte_out_r)
        BREAK_CODE: begin
          brk_s = 1'b1;
        end
        EXT_CODE: begin
          ext_s = 1'b1;
        end
        default: begin
          if (ext_r && (byte_out_r == LEFT_CODE)) begin
            left_s = ~brk_r;
          end else if (ext_r && (byte_out_r == RIGHT_CODE)) begin
            right_s = ~brk_r;
          end else if (!ext_r && (byte_out_r == FIRE_CODE)) begin
            fire_s = ~brk_r;
          end else begin
            fire_s = fire_r;
          end
          ext_s = 1'b0;
          brk_s = 1'b0;
        end
      endcase
    end else if (frame_err_r) begin
      ext_s = 1'b0;
      brk_s = 1'b0;
    end else begin
      ext_s = ext_r;
    end
  end

  // Decoder flags and held-key levels.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      ext_r   <= 1'b0;
      brk_r   <= 1'b0;
      left_r  <= 1'b0;
      right_r <= 1'b0;
      fire_r  <= 1'b0;
    end else begin
      ext_r   <= ext_s;
      brk_r   <= brk_s;
      left_r  <= left_s;
      right_r <= right_s;
      fire_r  <= fire_s;
    end
  end

  assign bus.left       = left_r;
  assign bus.right      = right_r;
  assign bus.fire       = fire_r;
  assign bus.byte_out   = byte_out_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_key_ctl.sv
// Directed bench for ps2_key_ctl: bit-banged PS/2 frames, byte scoreboard and
// key-level checks.
module tb_ps2_key_ctl;
  localparam int TO = 300;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  ps2_key_ctl_if bus ();

  ps2_key_ctl #(
    .TIMEOUT_CYCLES(TO),
    .LEFT_CODE     (8'h6B),
    .RIGHT_CODE    (8'h74),
    .FIRE_CODE     (8'h29)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks      = 0;
  int         n_fail        = 0;
  int         cyc           = 0;
  int         err_seen      = 0;
  int         err_cyc       = 0;
  int         valid_cyc     = 0;
  int         left_rise_cyc = 0;
  int         both_bad      = 0;
  logic       left_q        = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [7:0] last_good     = 8'h00;

  always @(posedge pclk) cyc <= cyc + 1;

  // Output monitor: pops the byte scoreboard and timestamps pulses.
  always @(negedge pclk) begin
    if (bus.byte_valid) begin
      valid_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL byte_unexpected: observed %0h expected none", bus.byte_out);
      end else begin
        exp_b = exp_q.pop_front();
        assert (bus.byte_out === exp_b) else begin
          n_fail++;
          $error("FAIL byte_out: observed %0h expected %0h", bus.byte_out, exp_b);
        end
      end
    end
    if (bus.frame_err) begin
      err_seen++;
      err_cyc = cyc;
    end
    if (bus.byte_valid && bus.frame_err) both_bad++;
    if (bus.left && !left_q) left_rise_cyc = cyc;
    left_q = bus.left;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // One PS/2 bit: data set up while clock is high, then a low phase; t_low is the drive cycle.
  task automatic send_bit(input logic b, output int t_low);
    bus.ps2_data = b;
    repeat (4) @(posedge pclk);
    #1;
    t_low = cyc;
    bus.ps2_clk = 1'b0;
    repeat (4) @(posedge pclk);
    #1;
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good);
    int   t;
    logic p;
    p = ~^b;
    if (!good) p = ~p;
    if (good) begin
      exp_q.push_back(b);
      last_good = b;
    end
    send_bit(1'b0, t);
    for (int i = 0; i < 8; i++) send_bit(b[i], t);
    send_bit(p, t);
    send_bit(1'b1, t);
    bus.ps2_data = 1'b1;
    idle(6);
  endtask

  initial begin
    int e0;
    int t;
    logic [7:0] part;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b0;
    idle(3);
    check("reset_outputs", {bus.left, bus.right, bus.fire, bus.byte_valid, bus.frame_err, bus.byte_out}, 32'h0);
    rst = 1'b1;
    idle(4);

    // Left press and release
    send_frame(8'hE0, 1'b1);
    send_frame(8'h6B, 1'b1);
    check("left_press", bus.left, 1);
    // stop fall N -> byte_valid N+1 -> key level N+2
    check("left_latency", left_rise_cyc - valid_cyc, 1);
    check("left_press_others", {bus.right, bus.fire}, 0);
    send_frame(8'hE0, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h6B, 1'b1);
    check("left_release", bus.left, 0);
    check("left_release_others", {bus.right, bus.fire}, 0);

    // Fire and cross-prefix
    send_frame(8'h29, 1'b1);
    check("fire_press", bus.fire, 1);
    send_frame(8'hE0, 1'b1);
    send_frame(8'h29, 1'b1);
    check("fire_ext_ignored", bus.fire, 1);
    send_frame(8'h6B, 1'b1);
    check("ext_cleared", bus.left, 0);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h29, 1'b1);
    check("fire_release", bus.fire, 0);

    // Parity error
    e0 = err_seen;
    send_frame(8'h6B, 1'b0);
    check("parity_err_pulses", err_seen - e0, 1);
    check("parity_byte_kept", bus.byte_out, last_good);
    check("parity_left", bus.left, 0);
    send_frame(8'hE0, 1'b1);
    send_frame(8'h74, 1'b1);
    check("right_press", bus.right, 1);

    // Timeout: start bit plus four data bits, then the clock stays high
    e0   = err_seen;
    part = 8'h5A;
    send_bit(1'b0, t);
    for (int i = 0; i < 4; i++) send_bit(part[i], t);
    bus.ps2_data = 1'b1;
    idle(TO + 10);
    check("timeout_pulses", err_seen - e0, 1);
    // fall at t+2, abort TO cycles later, registered pulse one cycle after that
    check("timeout_timing", err_cyc - t, TO + 3);
    send_frame(8'h29, 1'b1);
    check("fire_after_timeout", bus.fire, 1);

    // Reset mid-frame
    send_frame(8'hE0, 1'b1);
    send_frame(8'h6B, 1'b1);
    check("left_before_reset", bus.left, 1);
    send_bit(1'b0, t);
    for (int i = 0; i < 4; i++) send_bit(1'b1, t);
    rst = 1'b0;
    #1;
    check("reset_mid_frame", {bus.left, bus.right, bus.fire, bus.byte_valid, bus.frame_err, bus.byte_out}, 32'h0);
    idle(3);
    rst = 1'b1;
    idle(3);
    send_frame(8'hE0, 1'b1);
    send_frame(8'h6B, 1'b1);
    check("left_after_reset", {bus.left, bus.right, bus.fire}, 3'b100);

    // Both keys
    send_frame(8'hE0, 1'b1);
    send_frame(8'h74, 1'b1);
    check("both_keys", {bus.left, bus.right}, 2'b11);
    send_frame(8'hE0, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h6B, 1'b1);
    check("left_released_right_held", {bus.left, bus.right}, 2'b01);

    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);
    check("valid_err_exclusive", both_bad, 0);
    check("byte_out_final", bus.byte_out, 8'h6B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
